// File: rtl/fm_mem_pkg.sv
// Shared types and helpers for the FM coefficient/state memories.
package fm_mem_pkg;

   typedef enum logic {CLEAR, READY} regfile_state_t;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/multi_read_regfile_clear_seq.sv
// Clear sequencer: sweeps zeros across the whole array after reset or on request.
module regfile_clear_seq
   import fm_mem_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_req,
   output logic          busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   // One extra bit keeps the terminal compare clear of wrap-around.
   localparam logic [AW:0] LAST_ADDR = (AW+1)'(depth_of(AW) - 1);
   localparam logic [AW:0] ONE       = (AW+1)'(1);

   regfile_state_t state_q, state_d;
   logic [AW:0]    addr_q, addr_d;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      clr_we  = 1'b0;
      unique case (state_q)
         CLEAR: begin
            clr_we = 1'b1;
            if (addr_q == LAST_ADDR) begin
               state_d = READY;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + ONE;
            end
         end
         READY: begin
            if (clear_req) begin
               state_d = CLEAR;
               addr_d  = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            addr_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   assign busy     = (state_q == CLEAR);
   assign clr_addr = addr_q[AW-1:0];

endmodule

// File: rtl/multi_read_regfile.sv
// Single-write, multi-read register file with registered read ports and hardware clear.
module multi_read_regfile
   import fm_mem_pkg::*;
#(
   parameter int DW     = 16,
   parameter int AW     = 12,
   parameter int NR     = 2,
   parameter int BYPASS = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_req,
   input  logic                   wren,
   input  logic [AW-1:0]          w_addr,
   input  logic [DW-1:0]          w_data,
   input  logic [NR-1:0]          rden,
   input  logic [NR-1:0][AW-1:0]  r_addr,
   output logic [NR-1:0][DW-1:0]  r_data,
   output logic [NR-1:0]          r_valid,
   output logic                   busy
);

   localparam int DEPTH = depth_of(AW);

   logic [DW-1:0] mem [DEPTH];

   logic          clr_we;
   logic [AW-1:0] clr_addr;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;

   regfile_clear_seq #(.AW(AW)) u_clear_seq (
      .clk       (clk),
      .reset     (reset),
      .clear_req (clear_req),
      .busy      (busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   // The sweep owns the write port while it runs, so user writes are dropped.
   always_comb begin
      mem_we    = wren;
      mem_waddr = w_addr;
      mem_wdata = w_data;
      if (clr_we) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [DW-1:0] data_q, data_d;
      logic          valid_q, valid_d;

      always_comb begin
         data_d  = data_q;
         valid_d = 1'b0;
         if (!busy && rden[i]) begin
            valid_d = 1'b1;
            if ((BYPASS != 0) && wren && (w_addr == r_addr[i])) begin
               data_d = w_data;
            end else begin
               data_d = mem[r_addr[i]];
            end
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
         end
      end

      assign r_data[i]  = data_q;
      assign r_valid[i] = valid_q;
   end

endmodule

// File: tb/tb_multi_read_regfile.sv
// Directed bench driving a bypass and a non-bypass register file with identical stimulus.
module tb_multi_read_regfile;

   logic            clk;
   logic            reset;
   logic            clear_req;
   logic            wren;
   logic [3:0]      w_addr;
   logic [15:0]     w_data;
   logic [2:0]      rden;
   logic [2:0][3:0] r_addr;

   logic [2:0][15:0] rd_b1, rd_b0;
   logic [2:0]       rv_b1, rv_b0;
   logic             busy_b1, busy_b0;

   int compared   = 0;
   int mismatched = 0;
   int cnt;
   logic valid_seen;

   multi_read_regfile #(.DW(16), .AW(4), .NR(3), .BYPASS(1)) dut_b1 (
      .clk(clk), .reset(reset), .clear_req(clear_req), .wren(wren),
      .w_addr(w_addr), .w_data(w_data), .rden(rden), .r_addr(r_addr),
      .r_data(rd_b1), .r_valid(rv_b1), .busy(busy_b1)
   );

   multi_read_regfile #(.DW(16), .AW(4), .NR(3), .BYPASS(0)) dut_b0 (
      .clk(clk), .reset(reset), .clear_req(clear_req), .wren(wren),
      .w_addr(w_addr), .w_data(w_data), .rden(rden), .r_addr(r_addr),
      .r_data(rd_b0), .r_valid(rv_b0), .busy(busy_b0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one cycle of inputs, then samples 1 time unit after the rising edge.
   task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                                input logic [2:0] re, input logic [3:0] a0, input logic [3:0] a1,
                                input logic [3:0] a2, input logic cr);
      wren      = we;
      w_addr    = wa;
      w_data    = wd;
      rden      = re;
      r_addr[0] = a0;
      r_addr[1] = a1;
      r_addr[2] = a2;
      clear_req = cr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Holds the current inputs and counts cycles until busy drops, bounded.
   task automatic countBusy(output int n, output logic vseen);
      n     = 0;
      vseen = 1'b0;
      while ((busy_b1 || busy_b0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         vseen = vseen | (|rv_b1) | (|rv_b0);
      end
   endtask

   initial begin
      reset = 1'b1;
      wren = 1'b0; w_addr = '0; w_data = '0; rden = '0; r_addr = '0; clear_req = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checkOutput("reset_rdata_b1", 64'(rd_b1), 64'h0);
      checkOutput("reset_rvalid_b1", 64'(rv_b1), 64'h0);
      checkOutput("reset_busy_b1", 64'(busy_b1), 64'h1);
      checkOutput("reset_busy_b0", 64'(busy_b0), 64'h1);

      reset = 1'b0;
      countBusy(cnt, valid_seen);
      checkOutput("init_busy_cycles", 64'(cnt), 64'd16);
      checkOutput("init_busy_low_b0", 64'(busy_b0), 64'h0);

      applyStimulus(1'b0, 4'd0, 16'h0, 3'b111, 4'd0, 4'd1, 4'd2, 1'b0);
      checkOutput("first_read_data", 64'(rd_b1), 64'h0);
      checkOutput("first_read_valid", 64'(rv_b1), 64'h7);

      applyStimulus(1'b1, 4'd5, 16'hBEEF, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
      checkOutput("idle_valid", 64'(rv_b1), 64'h0);
      applyStimulus(1'b0, 4'd0, 16'h0, 3'b111, 4'd5, 4'd6, 4'd5, 1'b0);
      checkOutput("beef_p0", 64'(rd_b1[0]), 64'hBEEF);
      checkOutput("beef_p1", 64'(rd_b1[1]), 64'h0);
      checkOutput("beef_p2", 64'(rd_b1[2]), 64'hBEEF);
      checkOutput("beef_valid", 64'(rv_b1), 64'h7);
      checkOutput("beef_p2_b0", 64'(rd_b0[2]), 64'hBEEF);

      applyStimulus(1'b1, 4'd9, 16'hAAAA, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
      applyStimulus(1'b1, 4'd9, 16'h1234, 3'b001, 4'd9, 4'd0, 4'd0, 1'b0);
      checkOutput("bypass1_same_cycle", 64'(rd_b1[0]), 64'h1234);
      checkOutput("bypass0_same_cycle", 64'(rd_b0[0]), 64'hAAAA);
      checkOutput("same_cycle_valid", 64'(rv_b0), 64'h1);

      applyStimulus(1'b0, 4'd0, 16'h0, 3'b010, 4'd0, 4'd9, 4'd0, 1'b0);
      checkOutput("p1_only_valid", 64'(rv_b1), 64'h2);
      checkOutput("p1_next_cycle_b0", 64'(rd_b0[1]), 64'h1234);
      checkOutput("p0_hold_b1", 64'(rd_b1[0]), 64'h1234);
      checkOutput("p0_hold_b0", 64'(rd_b0[0]), 64'hAAAA);
      checkOutput("p2_hold", 64'(rd_b1[2]), 64'hBEEF);
      applyStimulus(1'b0, 4'd0, 16'h0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
      checkOutput("p1_pulse_one_cycle", 64'(rv_b1), 64'h0);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 4'(i), 16'h1000 + 16'(i), 3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
      end
      applyStimulus(1'b0, 4'd0, 16'h0, 3'b100, 4'd0, 4'd0, 4'd7, 1'b0);
      checkOutput("fill_read7", 64'(rd_b0[2]), 64'h1007);

      applyStimulus(1'b0, 4'd0, 16'h0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1);
      checkOutput("clear_busy_rise", 64'(busy_b1), 64'h1);
      wren = 1'b1; w_addr = 4'd3; w_data = 16'hFFFF; rden = 3'b111; clear_req = 1'b0;
      countBusy(cnt, valid_seen);
      checkOutput("clear_busy_cycles", 64'(cnt), 64'd16);
      checkOutput("clear_valid_quiet", 64'(valid_seen), 64'h0);
      checkOutput("clear_rdata_hold", 64'(rd_b1[2]), 64'h1007);

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 4'd0, 16'h0, 3'b011, 4'(i), 4'(i), 4'd0, 1'b0);
         checkOutput($sformatf("cleared_b1_%0d", i), 64'(rd_b1[0]), 64'h0);
         checkOutput($sformatf("cleared_b0_%0d", i), 64'(rd_b0[1]), 64'h0);
      end

      applyStimulus(1'b1, 4'd2, 16'h5A5A, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
      applyStimulus(1'b0, 4'd0, 16'h0, 3'b100, 4'd0, 4'd0, 4'd2, 1'b1);
      checkOutput("pre_reset_p2", 64'(rd_b1[2]), 64'h5A5A);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 4'd0, 16'h0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0);
      end
      reset = 1'b1;
      #1;
      checkOutput("midsweep_reset_rdata", 64'(rd_b1), 64'h0);
      checkOutput("midsweep_reset_rvalid", 64'(rv_b1), 64'h0);
      checkOutput("midsweep_reset_busy", 64'(busy_b1), 64'h1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      countBusy(cnt, valid_seen);
      checkOutput("restart_busy_cycles", 64'(cnt), 64'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
